// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with a small receive buffer and sticky error flags.
//
// Build option: define UART_RX_FIFO_EN for a 4-entry receive FIFO; without it the
// buffer is a single holding register.
//
// Ports:
//   CLK          system clock, all state changes on the rising edge
//   RESET_n      asynchronous active-low reset
//   UART_IN      asynchronous serial line, idle high, LSB first
//   DATA[7:0]    byte at the head of the buffer, meaningful while VALID=1
//   VALID        buffer holds at least one byte
//   READ         pop strobe, one byte per cycle while VALID=1
//   ERR_CLR      synchronous clear of FRAMING_ERR and OVERRUN
//   FRAMING_ERR  sticky, a stop bit was sampled low
//   OVERRUN      sticky, a completed byte was dropped because the buffer was full
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | line high, waiting for a falling edge
// START    | checking the start bit at its midpoint
// DATA     | sampling the 8 data bits, LSB first
// STOP     | sampling the stop bit, pushing the byte if it is high
// BREAK    | line stuck low (bad stop or reset), wait for it to go high

module uart_rx #(
    parameter int CLKS_PER_BIT = 5000
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       UART_IN,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READ,
    input  logic       ERR_CLR,
    output logic       FRAMING_ERR,
    output logic       OVERRUN
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_MID  = 16'(CLKS_PER_BIT / 2);

    logic        sync_meta;
    logic        sync_line;
    logic [2:0]  state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        cnt_last;
    logic        cnt_mid;
    logic        push_req;
    logic        fe_event;
    logic        pop;
    logic        buf_full;
    logic        accept;
    logic        overrun_event;

    // Reset value 1 keeps the receiver from seeing a false start bit on release.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
        end else begin
            sync_meta <= UART_IN;
            sync_line <= sync_meta;
        end
    end

    assign cnt_last = (bit_cnt == CNT_LAST);
    assign cnt_mid  = (bit_cnt == CNT_MID);
    assign push_req = (state == ST_STOP) && cnt_last && sync_line;
    assign fe_event = (state == ST_STOP) && cnt_last && !sync_line;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= ST_BREAK;
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!sync_line) begin
                        state   <= ST_START;
                        bit_cnt <= 16'd0;
                    end
                end
                ST_START: begin
                    if (cnt_mid) begin
                        bit_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        state   <= sync_line ? ST_IDLE : ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_last) begin
                        bit_cnt            <= 16'd0;
                        shift_reg[bit_idx] <= sync_line;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_last) begin
                        bit_cnt <= 16'd0;
                        state   <= sync_line ? ST_IDLE : ST_BREAK;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                ST_BREAK: begin
                    if (sync_line) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_BREAK;
            endcase
        end
    end

    // A pop in the same cycle frees the slot a full buffer needs for the push.
    assign pop           = READ && VALID;
    assign accept        = push_req && (!buf_full || pop);
    assign overrun_event = push_req && buf_full && !pop;

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_mem [0:3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_cnt;

    assign buf_full = (fifo_cnt == 3'd4);
    assign VALID    = (fifo_cnt != 3'd0);
    assign DATA     = fifo_mem[rd_ptr];

    // 2-bit pointers wrap modulo 4 on their own.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 8'd0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= shift_reg;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({accept, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
`else
    logic [7:0] hold_reg;
    logic       hold_full;

    assign buf_full = hold_full;
    assign VALID    = hold_full;
    assign DATA     = hold_reg;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            hold_reg  <= 8'd0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= shift_reg;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end
`endif

    // A new error event takes priority over ERR_CLR in the same cycle.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            FRAMING_ERR <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            FRAMING_ERR <= fe_event | (FRAMING_ERR & ~ERR_CLR);
            OVERRUN     <= overrun_event | (OVERRUN & ~ERR_CLR);
        end
    end

endmodule
